// File: rtl/adc_stim_gen_if.sv
// ---------------------------------------------------------------------------
// adc_stim_gen_if
// Bundle between the ADC stimulus generator and whoever controls it and
// watches its output pins.
//
// Signals
//   i_enable        run when high; DCO and data freeze when low
//   i_mode          0 ramp, 1 constant, 2 alternating, 3 PRBS
//   i_const         value used by the constant and alternating modes
//   i_half_period   i_clock cycles per DCO half period (0 behaves as 1)
//   o_dco           generated data clock
//   o_data          channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_sample_stb    one-cycle pulse in the cycle o_data updates
//   o_sample_count  updates since reset, wraps at 2^32
//
// Modports
//   master  controller side: drives the i_* controls, observes the o_* pins
//   slave   generator side
// ---------------------------------------------------------------------------
interface adc_stim_gen_if #(
  parameter int DATA_WIDTH   = 14,
  parameter int NUM_CHANNELS = 1,
  parameter int DIV_WIDTH    = 8
);
  logic                               i_enable;
  logic [1:0]                         i_mode;
  logic [DATA_WIDTH-1:0]              i_const;
  logic [DIV_WIDTH-1:0]               i_half_period;
  logic                               o_dco;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] o_data;
  logic                               o_sample_stb;
  logic [31:0]                        o_sample_count;

  modport master (
    output i_enable,
    output i_mode,
    output i_const,
    output i_half_period,
    input  o_dco,
    input  o_data,
    input  o_sample_stb,
    input  o_sample_count
  );

  modport slave (
    input  i_enable,
    input  i_mode,
    input  i_const,
    input  i_half_period,
    output o_dco,
    output o_data,
    output o_sample_stb,
    output o_sample_count
  );
endinterface

// File: rtl/adc_stim_gen.sv
// ---------------------------------------------------------------------------
// adc_stim_gen
// ADC front-end stimulus: a programmable-rate DCO plus NUM_CHANNELS lanes of
// DATA_WIDTH-bit sample data. Data changes on the DCO falling edge so it is
// stable across the following rising edge. All outputs are registered in the
// i_clock domain.
//
// Parameters
//   DATA_WIDTH    bits per channel sample (2..32)
//   NUM_CHANNELS  parallel sample lanes (1..8)
//   DIV_WIDTH     width of the DCO half-period setting
//
// Ports
//   i_clock  system clock, rising edge
//   i_reset  asynchronous, active-high reset
//   bus      adc_stim_gen_if.slave (controls in, DCO/data/strobe/count out)
// ---------------------------------------------------------------------------
module adc_stim_gen #(
  parameter int DATA_WIDTH   = 14,
  parameter int NUM_CHANNELS = 1,
  parameter int DIV_WIDTH    = 8
) (
  input logic           i_clock,
  input logic           i_reset,
  adc_stim_gen_if.slave bus
);

  localparam int OUT_W = NUM_CHANNELS * DATA_WIDTH;

  // Galois form of x^32+x^22+x^2+x+1, shifting toward bit 0.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'h0000_0001;

  localparam logic [DIV_WIDTH-1:0]  DIV_ONE  = DIV_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] DATA_ONE = DATA_WIDTH'(1);

  // DCO timing
  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] h_lat_q;
  logic [DIV_WIDTH-1:0] h_live;
  logic [DIV_WIDTH-1:0] h_cur;
  logic                 first_q;
  logic                 dco_q;
  logic                 toggle;
  logic                 update;

  // Data generation
  logic [DATA_WIDTH-1:0] base_q;
  logic [DATA_WIDTH-1:0] base_nxt;
  logic                  phase_q;
  logic [31:0]           lfsr_q;
  logic [31:0]           lfsr_nxt;
  logic [OUT_W-1:0]      data_q;
  logic [OUT_W-1:0]      data_nxt;
  logic                  stb_q;
  logic [31:0]           count_q;

  assign h_live = (bus.i_half_period == '0) ? DIV_ONE : bus.i_half_period;

  // The half-period length is latched at every toggle so that a mid-period
  // change of i_half_period only affects the next half period. Between reset
  // and the first toggle there is no latched value yet, so the live setting
  // is used.
  assign h_cur  = first_q ? h_live : h_lat_q;
  assign toggle = bus.i_enable && (cnt_q == (h_cur - DIV_ONE));
  assign update = toggle && dco_q;

  always_comb begin
    base_nxt = base_q;
    lfsr_nxt = lfsr_q;
    data_nxt = data_q;
    case (bus.i_mode)
      2'd0: begin
        base_nxt = base_q + DATA_ONE;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
          data_nxt[k*DATA_WIDTH +: DATA_WIDTH] = base_nxt + DATA_WIDTH'(k);
        end
      end
      2'd1: begin
        for (int k = 0; k < NUM_CHANNELS; k++) begin
          data_nxt[k*DATA_WIDTH +: DATA_WIDTH] = bus.i_const;
        end
      end
      2'd2: begin
        for (int k = 0; k < NUM_CHANNELS; k++) begin
          data_nxt[k*DATA_WIDTH +: DATA_WIDTH] = phase_q ? ~bus.i_const : bus.i_const;
        end
      end
      default: begin
        // Nonzero seed and a primitive polynomial keep the LFSR off all-zero.
        lfsr_nxt = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
        for (int k = 0; k < NUM_CHANNELS; k++) begin
          data_nxt[k*DATA_WIDTH +: DATA_WIDTH] = lfsr_nxt[DATA_WIDTH-1:0] ^ DATA_WIDTH'(k);
        end
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      cnt_q   <= '0;
      h_lat_q <= '0;
      first_q <= 1'b1;
      dco_q   <= 1'b0;
      base_q  <= '0;
      phase_q <= 1'b0;
      lfsr_q  <= LFSR_SEED;
      data_q  <= '0;
      stb_q   <= 1'b0;
      count_q <= '0;
    end else begin
      stb_q <= update;
      if (bus.i_enable) begin
        if (toggle) begin
          cnt_q   <= '0;
          dco_q   <= ~dco_q;
          h_lat_q <= h_live;
          first_q <= 1'b0;
        end else begin
          cnt_q <= cnt_q + DIV_ONE;
        end
      end
      if (update) begin
        data_q  <= data_nxt;
        base_q  <= base_nxt;
        lfsr_q  <= lfsr_nxt;
        count_q <= count_q + 32'd1;
        if (bus.i_mode == 2'd2) begin
          phase_q <= ~phase_q;
        end
      end
    end
  end

  assign bus.o_dco          = dco_q;
  assign bus.o_data         = data_q;
  assign bus.o_sample_stb   = stb_q;
  assign bus.o_sample_count = count_q;

endmodule

// File: tb/tb_adc_stim_gen.sv
module tb_adc_stim_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en;
  logic [1:0] mode;
  logic [13:0] cst;
  logic [7:0] hp;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Two instances: the default 14-bit single lane, and a 4-bit three-lane
  // build for the wrap and per-channel offset behaviour.
  adc_stim_gen_if #(.DATA_WIDTH(14), .NUM_CHANNELS(1), .DIV_WIDTH(8)) bus_a ();
  adc_stim_gen_if #(.DATA_WIDTH(4),  .NUM_CHANNELS(3), .DIV_WIDTH(8)) bus_b ();

  assign bus_a.i_enable      = en;
  assign bus_a.i_mode        = mode;
  assign bus_a.i_const       = cst;
  assign bus_a.i_half_period = hp;
  assign bus_b.i_enable      = en;
  assign bus_b.i_mode        = mode;
  assign bus_b.i_const       = cst[3:0];
  assign bus_b.i_half_period = hp;

  adc_stim_gen #(.DATA_WIDTH(14), .NUM_CHANNELS(1), .DIV_WIDTH(8)) dut_a (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus_a)
  );

  adc_stim_gen #(.DATA_WIDTH(4), .NUM_CHANNELS(3), .DIV_WIDTH(8)) dut_b (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model: DCO as "H enabled cycles per half period", data as
  // a function of update index / mode history.
  // ------------------------------------------------------------------
  logic        m_dco;
  logic        m_stb;
  logic [31:0] m_base;
  logic        m_phase;
  logic [31:0] m_lfsr;
  logic [31:0] m_count;
  logic [13:0] m_data_a;
  logic [11:0] m_data_b;
  int          m_elapsed;
  int          m_hlat;
  int          h_now;

  function automatic logic [31:0] prbs_next(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  function automatic int eff_h(input logic [7:0] v);
    return (v == 8'd0) ? 1 : int'(v);
  endfunction

  task automatic model_update();
    logic [3:0] c4;
    c4 = cst[3:0];
    case (mode)
      2'd0: begin
        m_base   = m_base + 1;
        m_data_a = m_base[13:0];
        for (int k = 0; k < 3; k++) m_data_b[k*4 +: 4] = m_base[3:0] + 4'(k);
      end
      2'd1: begin
        m_data_a = cst;
        for (int k = 0; k < 3; k++) m_data_b[k*4 +: 4] = c4;
      end
      2'd2: begin
        m_data_a = m_phase ? ~cst : cst;
        for (int k = 0; k < 3; k++) m_data_b[k*4 +: 4] = m_phase ? ~c4 : c4;
        m_phase = ~m_phase;
      end
      default: begin
        m_lfsr   = prbs_next(m_lfsr);
        m_data_a = m_lfsr[13:0];
        for (int k = 0; k < 3; k++) m_data_b[k*4 +: 4] = m_lfsr[3:0] ^ 4'(k);
      end
    endcase
    m_count = m_count + 1;
    m_stb   = 1'b1;
  endtask

  always begin
    @(posedge clk);
    if (rst) begin
      m_dco = 0; m_stb = 0; m_base = 0; m_phase = 0; m_lfsr = 32'h1;
      m_count = 0; m_data_a = 0; m_data_b = 0; m_elapsed = 0; m_hlat = 0;
    end else begin
      m_stb = 1'b0;
      if (en) begin
        m_elapsed = m_elapsed + 1;
        h_now = (m_hlat == 0) ? eff_h(hp) : m_hlat;
        if (m_elapsed >= h_now) begin
          m_elapsed = 0;
          m_hlat    = eff_h(hp);
          if (m_dco) model_update();
          m_dco = ~m_dco;
        end
      end
    end
    #1;
    chk("dco_a",   bus_a.o_dco,          m_dco);
    chk("dco_b",   bus_b.o_dco,          m_dco);
    chk("stb_a",   bus_a.o_sample_stb,   m_stb);
    chk("stb_b",   bus_b.o_sample_stb,   m_stb);
    chk("data_a",  bus_a.o_data,         m_data_a);
    chk("data_b",  bus_b.o_data,         m_data_b);
    chk("count_a", bus_a.o_sample_count, m_count);
    chk("count_b", bus_b.o_sample_count, m_count);
  end

  // ------------------------------------------------------------------
  // Directed stimulus with hand-computed expectations
  // ------------------------------------------------------------------
  task automatic wait_stb(input int limit, output int cycles);
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
    end while (!bus_a.o_sample_stb && cycles < limit);
    if (!bus_a.o_sample_stb) chk("stb_timeout", 64'd0, 64'd1);
  endtask

  int n;
  logic [31:0] cnt_snap;
  logic [13:0] data_snap;
  logic        dco_snap;

  initial begin
    en = 0; mode = 2'd0; cst = 14'h0; hp = 8'd2;
    repeat (2) @(negedge clk);
    chk("reset_dco",   bus_a.o_dco, 0);
    chk("reset_data",  bus_a.o_data, 0);
    chk("reset_count", bus_a.o_sample_count, 0);
    chk("reset_datab", bus_b.o_data, 0);

    // Ramp, H=2: first update at end of cycle 2H, then one per 4 clocks.
    rst = 0; en = 1;
    wait_stb(20, n);
    chk("first_latency", n, 4);
    chk("ramp_first", bus_a.o_data, 14'd1);
    chk("ramp_count1", bus_a.o_sample_count, 1);
    wait_stb(20, n);
    chk("dco_period", n, 4);
    chk("ramp_second", bus_a.o_data, 14'd2);
    repeat (13) wait_stb(20, n);
    chk("wrap_15", bus_b.o_data, 12'h10F);
    wait_stb(20, n);
    chk("wrap_16", bus_b.o_data, 12'h210);
    chk("ramp_16", bus_a.o_data, 14'd16);

    // Alternating, then a mid-period switch to constant.
    @(negedge clk); mode = 2'd2; cst = 14'h0A5A;
    wait_stb(20, n);
    chk("alt_0", bus_a.o_data, 14'h0A5A);
    chk("alt_0b", bus_b.o_data, 12'hAAA);
    wait_stb(20, n);
    chk("alt_1", bus_a.o_data, 14'h35A5);
    chk("alt_1b", bus_b.o_data, 12'h555);
    wait_stb(20, n);
    chk("alt_2", bus_a.o_data, 14'h0A5A);
    @(negedge clk); mode = 2'd1; cst = 14'h1234;
    @(posedge clk); #1;
    chk("mid_period_hold", bus_a.o_data, 14'h0A5A);
    wait_stb(20, n);
    chk("const_a", bus_a.o_data, 14'h1234);
    chk("const_b", bus_b.o_data, 12'h444);

    // PRBS from reset.
    @(negedge clk); rst = 1; mode = 2'd3;
    @(negedge clk); rst = 0;
    wait_stb(20, n);
    chk("prbs_1", bus_a.o_data, 14'h0003);
    chk("prbs_1b", bus_b.o_data, 12'h123);
    wait_stb(20, n);
    chk("prbs_2", bus_a.o_data, 14'h0002);
    wait_stb(20, n);
    chk("prbs_3", bus_a.o_data, 14'h0001);

    // Half period 0 behaves as 1; long PRBS run at the fast rate.
    @(negedge clk); hp = 8'd0;
    cnt_snap = bus_a.o_sample_count;
    for (int i = 0; i < 10000; i++) wait_stb(20, n);
    chk("prbs_run_count", bus_a.o_sample_count, cnt_snap + 32'd10000);
    wait_stb(20, n);
    chk("hp0_spacing", n, 2);

    // Freeze for 5 cycles.
    @(negedge clk); en = 0;
    dco_snap = bus_a.o_dco; data_snap = bus_a.o_data; cnt_snap = bus_a.o_sample_count;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("frz_dco", bus_a.o_dco, dco_snap);
      chk("frz_data", bus_a.o_data, data_snap);
      chk("frz_count", bus_a.o_sample_count, cnt_snap);
      chk("frz_stb", bus_a.o_sample_stb, 0);
    end
    @(negedge clk); en = 1;
    wait_stb(20, n);
    chk("resume_spacing", n, 2);

    // Reset between DCO edges after 7 ramp updates.
    @(negedge clk); rst = 1; mode = 2'd0; hp = 8'd2;
    @(negedge clk); rst = 0;
    repeat (7) wait_stb(20, n);
    chk("pre_reset_data", bus_a.o_data, 14'd7);
    @(negedge clk);
    @(posedge clk); #3; rst = 1; #1;
    chk("arst_dco", bus_a.o_dco, 0);
    chk("arst_data", bus_a.o_data, 0);
    chk("arst_count", bus_a.o_sample_count, 0);
    chk("arst_datab", bus_b.o_data, 0);
    @(negedge clk); @(negedge clk); rst = 0;
    wait_stb(20, n);
    chk("post_reset_latency", n, 4);
    chk("post_reset_ramp", bus_a.o_data, 14'd1);

    // Half-period change: takes effect at the following toggle.
    @(negedge clk); hp = 8'd3;
    wait_stb(20, n);
    chk("hchg_first", n, 5);
    wait_stb(20, n);
    chk("hchg_steady", n, 6);
    @(negedge clk); @(negedge clk); hp = 8'd5;
    wait_stb(30, n);
    chk("hchg_mid", n, 8 - 1);
    wait_stb(30, n);
    chk("hchg_new", n, 10);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
